// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
// The arbiter places the MA pipeline stage and an external loader/debug
// port in front of one synchronous data-memory port pair.
package dmem_port_arbiter_pkg;

  localparam int DMEM_ADDR_WIDTH   = 10;
  localparam int DMEM_DATA_WIDTH   = 32;
  localparam int DMEM_STARVE_LIMIT = 4;

  // Arbiter FSM: IDLE accepts grants. RD_x is the single cycle in which a
  // granted read returns its data.
  typedef enum logic [1:0] {
    IDLE,
    RD_MA,
    RD_EXT
  } arb_state_e;

  // Records which requester owns the read that is in flight.
  typedef enum logic {
    OWN_MA,
    OWN_EXT
  } arb_owner_e;

  // One memory access request, sized to the default memory geometry.
  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the MA stage and an external
// loader/debug port. Writes complete in their grant cycle. Reads use the
// memory's 1-cycle latency, so the arbiter holds off further grants for
// one cycle while the read data returns to its owner.
// Optional anti-starvation for the external port: define DMEM_ARB_STARVE_EN.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int STARVE_LIMIT   = DMEM_STARVE_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ma_req,
  input  logic                      ma_we,
  input  logic [MEM_ADDR_WIDTH-1:0] ma_addr,
  input  logic [MEM_DATA_WIDTH-1:0] ma_wdata,
  output logic                      ma_gnt,
  output logic                      ma_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] ma_rdata,
  output logic                      ma_stall,
  input  logic                      ext_req,
  input  logic                      ext_we,
  input  logic [MEM_ADDR_WIDTH-1:0] ext_addr,
  input  logic [MEM_DATA_WIDTH-1:0] ext_wdata,
  output logic                      ext_gnt,
  output logic                      ext_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] ext_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_waddr,
  output logic [MEM_DATA_WIDTH-1:0] dmem_wdata,
  output logic                      dmem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_raddr,
  output logic                      dmem_ren,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata
);

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } port_req_t;

  arb_state_e state_q, state_d;
  arb_owner_e rd_owner_q, rd_owner_d;
  logic       starve_force;
  logic       ma_win;
  logic       ext_win;
  port_req_t  win_req;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q == CNT_MAX);

  // Count contended IDLE cycles that the external port loses, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ext_win) begin
      starve_cnt_d = '0;
    end else if (ma_win && ext_req && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_starve_cfg;

  assign starve_force      = 1'b0;
  assign unused_starve_cfg = ^STARVE_LIMIT;
`endif

  // Pick at most one winner per IDLE cycle: MA first, unless ext is being forced.
  always_comb begin
    ma_win  = 1'b0;
    ext_win = 1'b0;
    if (rst && (state_q == IDLE)) begin
      if (ma_req && !(starve_force && ext_req)) begin
        ma_win = 1'b1;
      end else if (ext_req) begin
        ext_win = 1'b1;
      end
    end
  end

  // Route the winner onto the memory port and sequence reads through RD_x.
  always_comb begin
    win_req.we    = ma_we;
    win_req.addr  = ma_addr;
    win_req.wdata = ma_wdata;
    dmem_wen      = 1'b0;
    dmem_waddr    = '0;
    dmem_wdata    = '0;
    dmem_ren      = 1'b0;
    dmem_raddr    = '0;
    state_d       = IDLE;
    rd_owner_d    = rd_owner_q;
    if (ext_win) begin
      win_req.we    = ext_we;
      win_req.addr  = ext_addr;
      win_req.wdata = ext_wdata;
    end
    if (ma_win || ext_win) begin
      if (win_req.we) begin
        dmem_wen   = 1'b1;
        dmem_waddr = win_req.addr;
        dmem_wdata = win_req.wdata;
      end else begin
        dmem_ren   = 1'b1;
        dmem_raddr = win_req.addr;
        state_d    = ext_win ? RD_EXT : RD_MA;
        rd_owner_d = ext_win ? OWN_EXT : OWN_MA;
      end
    end
  end

  // Return read data to its owner only; the other requester sees zero.
  always_comb begin
    ma_rvalid  = 1'b0;
    ma_rdata   = '0;
    ext_rvalid = 1'b0;
    ext_rdata  = '0;
    if (rst && (state_q != IDLE)) begin
      if (rd_owner_q == OWN_EXT) begin
        ext_rvalid = 1'b1;
        ext_rdata  = dmem_rdata;
      end else begin
        ma_rvalid = 1'b1;
        ma_rdata  = dmem_rdata;
      end
    end
  end

  assign ma_gnt   = ma_win;
  assign ext_gnt  = ext_win;
  assign ma_stall = rst && ma_req && !ma_win;

  // FSM state and read-owner registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_owner_q <= OWN_MA;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // A requester must keep asking until it is granted.
  ma_req_hold : assert property (@(posedge clk) disable iff (!rst)
    (ma_req && !ma_gnt) |=> ma_req);

  ext_req_hold : assert property (@(posedge clk) disable iff (!rst)
    (ext_req && !ext_gnt) |=> ext_req);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter. A behavioural memory sits on
// the dmem port. A cycle-level reference model derives the grants, memory
// traffic, read returns and stalls from the arbitration rules.
// Honours DMEM_ARB_STARVE_EN in the same way as the design.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int AW    = DMEM_ADDR_WIDTH;
  localparam int DW    = DMEM_DATA_WIDTH;
  localparam int LIMIT = DMEM_STARVE_LIMIT;

  logic          clk = 1'b0;
  logic          rst;
  logic          ma_req, ma_we, ma_gnt, ma_rvalid, ma_stall;
  logic [AW-1:0] ma_addr;
  logic [DW-1:0] ma_wdata, ma_rdata;
  logic          ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic [AW-1:0] dmem_waddr, dmem_raddr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          dmem_wen, dmem_ren;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ma_req     (ma_req),
    .ma_we      (ma_we),
    .ma_addr    (ma_addr),
    .ma_wdata   (ma_wdata),
    .ma_gnt     (ma_gnt),
    .ma_rvalid  (ma_rvalid),
    .ma_rdata   (ma_rdata),
    .ma_stall   (ma_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .dmem_waddr (dmem_waddr),
    .dmem_wdata (dmem_wdata),
    .dmem_wen   (dmem_wen),
    .dmem_raddr (dmem_raddr),
    .dmem_ren   (dmem_ren),
    .dmem_rdata (dmem_rdata)
  );

  // Synchronous data memory with 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (dmem_wen) mem[dmem_waddr] <= dmem_wdata;
    if (dmem_ren) dmem_rdata <= mem[dmem_raddr];
  end

  int            total_checks = 0;
  int            bad_checks   = 0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            pend_owner;
  logic [DW-1:0] pend_data;
  int            starve;
  logic          last_ma_win, last_ext_win;
  logic [1:0]    obs_gnt;
  logic          obs_ext_rvalid;
  logic [DW-1:0] obs_ma_rdata, obs_ext_rdata;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    assert (got === exp) else begin
      bad_checks++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive a new request on one port; it stays raised until granted.
  task automatic apply_stimulus(input logic to_ext, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data);
    if (to_ext) begin
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = data;
    end else begin
      ma_req = 1'b1; ma_we = we; ma_addr = addr; ma_wdata = data;
    end
  endtask

  // One clock cycle: compare every output with the model, then advance the model.
  task automatic check_output();
    logic          e_ma, e_ext, w_we, force_ext, e_wen, e_ren, e_ma_rv, e_ext_rv, e_stall;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    @(negedge clk);
    if (!rst) begin
      pend_owner = 0;
      starve     = 0;
    end
    force_ext = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
    force_ext = (starve == LIMIT);
`endif
    e_ma     = rst && (pend_owner == 0) && ma_req && !(force_ext && ext_req);
    e_ext    = rst && (pend_owner == 0) && ext_req && !e_ma;
    w_we     = e_ext ? ext_we : ma_we;
    w_addr   = e_ext ? ext_addr : ma_addr;
    w_data   = e_ext ? ext_wdata : ma_wdata;
    e_wen    = (e_ma || e_ext) && w_we;
    e_ren    = (e_ma || e_ext) && !w_we;
    e_ma_rv  = rst && (pend_owner == 1);
    e_ext_rv = rst && (pend_owner == 2);
    e_stall  = rst && ma_req && !e_ma;
    expect_eq("gnt", 64'({ma_gnt, ext_gnt}), 64'({e_ma, e_ext}));
    expect_eq("ma_ret", 64'({ma_rvalid, ma_rdata}), 64'({e_ma_rv, e_ma_rv ? pend_data : {DW{1'b0}}}));
    expect_eq("ext_ret", 64'({ext_rvalid, ext_rdata}), 64'({e_ext_rv, e_ext_rv ? pend_data : {DW{1'b0}}}));
    expect_eq("wport", 64'({dmem_wen, dmem_waddr, dmem_wdata}),
              64'({e_wen, e_wen ? w_addr : {AW{1'b0}}, e_wen ? w_data : {DW{1'b0}}}));
    expect_eq("rport", 64'({dmem_ren, dmem_raddr}), 64'({e_ren, e_ren ? w_addr : {AW{1'b0}}}));
    expect_eq("stall", 64'(ma_stall), 64'(e_stall));
    obs_gnt        = {ma_gnt, ext_gnt};
    obs_ext_rvalid = ext_rvalid;
    obs_ma_rdata   = ma_rdata;
    obs_ext_rdata  = ext_rdata;
    last_ma_win    = e_ma;
    last_ext_win   = e_ext;
    @(posedge clk);
    if (rst) begin
      if (e_ren) pend_data = ref_mem[w_addr];
      if (e_wen) ref_mem[w_addr] = w_data;
      pend_owner = e_ren ? (e_ma ? 1 : 2) : 0;
`ifdef DMEM_ARB_STARVE_EN
      if (e_ext) starve = 0;
      else if (e_ma && ext_req && (starve < LIMIT)) starve++;
`endif
    end
    #1;
  endtask

  task automatic service_cycle();
    check_output();
    if (last_ma_win) ma_req = 1'b0;
    if (last_ext_win) ext_req = 1'b0;
  endtask

  task automatic service_until_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!ma_req && !ext_req) break;
      service_cycle();
    end
    if (ma_req || ext_req) begin
      total_checks++;
      bad_checks++;
      $error("[TB] FAIL grant_timeout observed=pending expected=granted");
      ma_req  = 1'b0;
      ext_req = 1'b0;
    end
  endtask

  initial begin
    int ext_grants;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    pend_owner = 0; pend_data = '0; starve = 0;
    rst = 1'b0;
    ma_req = 1'b0; ma_we = 1'b0; ma_addr = '0; ma_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

    $display("[TB] reset with both ports requesting");
    apply_stimulus(1'b0, 1'b1, AW'(32), 32'h1111_2222);
    apply_stimulus(1'b1, 1'b1, AW'(33), 32'h3333_4444);
    repeat (3) check_output();
    rst = 1'b1;
    check_output();
    expect_eq("t1_ma_first", 64'(obs_gnt), 64'(2'b10));
    ma_req = 1'b0;
    service_until_idle(4);

    $display("[TB] MA store then load");
    apply_stimulus(1'b0, 1'b1, AW'(16), 32'hDEAD_BEEF);
    service_until_idle(4);
    apply_stimulus(1'b0, 1'b0, AW'(16), 32'h0);
    service_until_idle(4);
    check_output();
    expect_eq("t2_load_data", 64'(obs_ma_rdata), 64'(32'hDEAD_BEEF));

    $display("[TB] back-to-back ext writes then reads");
    for (int a = 0; a < 16; a++) begin
      apply_stimulus(1'b1, 1'b1, AW'(a), $urandom);
      service_cycle();
      expect_eq("t6_wr_gnt", 64'(obs_gnt), 64'(2'b01));
    end
    ext_req = 1'b0;
    for (int a = 0; a < 8; a++) begin
      apply_stimulus(1'b1, 1'b0, AW'(a), 32'h0);
      service_until_idle(4);
      check_output();
      expect_eq("t6_rd_data", 64'(obs_ext_rdata), 64'(ref_mem[a]));
    end

    $display("[TB] contention on reads");
    apply_stimulus(1'b0, 1'b0, AW'(1), 32'h0);
    apply_stimulus(1'b1, 1'b0, AW'(2), 32'h0);
    check_output();
    expect_eq("t3_ma_wins", 64'(obs_gnt), 64'(2'b10));
    apply_stimulus(1'b0, 1'b0, AW'(3), 32'h0);
    service_until_idle(10);
    check_output();

    $display("[TB] starvation under continuous MA writes");
    ext_grants = 0;
    apply_stimulus(1'b1, 1'b0, AW'(3), 32'h0);
    apply_stimulus(1'b0, 1'b1, AW'($urandom_range(0, 15)), $urandom);
    for (int c = 0; c < 10; c++) begin
      check_output();
      if (last_ext_win) begin
        ext_req = 1'b0;
        ext_grants++;
      end
      if (last_ma_win) apply_stimulus(1'b0, 1'b1, AW'($urandom_range(0, 15)), $urandom);
    end
`ifdef DMEM_ARB_STARVE_EN
    expect_eq("t4_ext_grants", 64'(ext_grants), 64'(1));
`else
    expect_eq("t4_ext_grants", 64'(ext_grants), 64'(0));
`endif
    service_until_idle(6);
    check_output();

    $display("[TB] reset during an ext read");
    apply_stimulus(1'b1, 1'b0, AW'(5), 32'h0);
    service_until_idle(4);
    rst = 1'b0;
    check_output();
    expect_eq("t5_no_rvalid", 64'(obs_ext_rvalid), 64'(0));
    check_output();
    rst = 1'b1;
    check_output();
    apply_stimulus(1'b1, 1'b0, AW'(6), 32'h0);
    service_until_idle(4);
    check_output();
    expect_eq("t5_rvalid", 64'(obs_ext_rvalid), 64'(1));
    expect_eq("t5_data", 64'(obs_ext_rdata), 64'(ref_mem[6]));

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      if (!ma_req && ($urandom_range(0, 2) != 0))
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      if (!ext_req && ($urandom_range(0, 1) != 0))
        apply_stimulus(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      service_cycle();
    end
    service_until_idle(20);
    repeat (2) check_output();

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
